// File: rtl/dcache_axi_mem_slave.sv
// ----------------------------------------------------------------------------
// dcache_axi_mem_slave : burst AXI responder serving the dcache from a word RAM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dcache_axi_mem_slave #(
  parameter int ADDR_W      = 14,
  parameter int READ_LAT    = 2,
  parameter int WRITE_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_arvalid,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  output logic        d_arready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  input  logic        d_rready,
  input  logic        d_awvalid,
  input  logic [31:0] d_awaddr,
  input  logic [7:0]  d_awlen,
  input  logic [2:0]  d_awsize,
  output logic        d_awready,
  input  logic        d_wvalid,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  output logic        d_wready,
  output logic        d_bvalid,
  input  logic        d_bready,
  output logic        protocol_err
);

  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_LAT   = 3'd1,
    RD_BURST = 3'd2,
    WR_DATA  = 3'd3,
    WR_RESP  = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] index, index_inc;
  logic [7:0]        len, beat, beat_inc;
  logic [LAT_W-1:0]  lat_cnt;
  logic [31:0]       mem [2**ADDR_W];
  logic              ar_hs, aw_hs;

  // Size fields and out-of-range address bits carry no information here.
  logic unused_ok;
  assign unused_ok = ^{d_arsize, d_awsize, d_araddr[31:ADDR_W+2], d_araddr[1:0],
                       d_awaddr[31:ADDR_W+2], d_awaddr[1:0]};

  assign index_inc = index + ADDR_W'(1);
  assign beat_inc  = beat + 8'd1;
  assign ar_hs     = d_arvalid && d_arready;
  assign aw_hs     = d_awvalid && d_awready;
  assign d_rvalid  = (state == RD_BURST);
  assign d_bvalid  = (state == WR_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    d_arready = 1'b0;
    d_awready = 1'b0;
    d_wready  = 1'b0;
    case (state)
      IDLE: begin
        // Readies are masked while reset is held so every output reads 0.
        if (!rst) begin
          d_awready = !(WRITE_FIRST == 0 && d_arvalid);
          d_arready = !(WRITE_FIRST != 0 && d_awvalid);
          if (d_awvalid && d_awready)      state_nx = WR_DATA;
          else if (d_arvalid && d_arready) state_nx = RD_LAT;
        end
      end
      RD_LAT:   if (lat_cnt == '0) state_nx = RD_BURST;
      RD_BURST: if (d_rready && d_rlast) state_nx = IDLE;
      WR_DATA: begin
        d_wready = 1'b1;
        if (d_wvalid && d_wlast) state_nx = WR_RESP;
      end
      WR_RESP:  if (d_bready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index        <= '0;
      len          <= '0;
      beat         <= '0;
      lat_cnt      <= '0;
      d_rdata      <= '0;
      d_rlast      <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            index <= d_awaddr[ADDR_W+1:2];
            len   <= d_awlen;
            beat  <= '0;
          end else if (ar_hs) begin
            index   <= d_araddr[ADDR_W+1:2];
            len     <= d_arlen;
            beat    <= '0;
            lat_cnt <= LAT_W'(READ_LAT - 1);
          end
        end
        RD_LAT: begin
          if (lat_cnt == '0) begin
            d_rdata <= mem[index];
            d_rlast <= (len == 8'd0);
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RD_BURST: begin
          if (d_rready) begin
            if (d_rlast) begin
              d_rlast <= 1'b0;
            end else begin
              index   <= index_inc;
              beat    <= beat_inc;
              d_rdata <= mem[index_inc];
              d_rlast <= (beat_inc == len);
            end
          end
        end
        WR_DATA: begin
          if (d_wvalid) begin
            index <= index_inc;
            beat  <= beat_inc;
            // Early wlast, or a missing wlast on the final beat, is a burst-length error.
            if (d_wlast != (beat == len)) protocol_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Reads happen only in RD_* states and writes only in WR_DATA, so a
  // same-cycle read/write collision on the array cannot occur.
  always_ff @(posedge clk) begin
    if (state == WR_DATA && d_wvalid) begin
      for (int i = 0; i < 4; i++) begin
        if (d_wstrb[i]) mem[index][8*i +: 8] <= d_wdata[8*i +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_axi_mem_slave.sv
// ----------------------------------------------------------------------------
// tb_dcache_axi_mem_slave : vector table + read scoreboard for the AXI mem slave
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dcache_axi_mem_slave;

  localparam int READ_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_arvalid, d_rready, d_awvalid, d_wvalid, d_wlast, d_bready;
  logic [31:0] d_araddr, d_awaddr, d_wdata;
  logic [7:0]  d_arlen, d_awlen;
  logic [2:0]  d_arsize, d_awsize;
  logic [3:0]  d_wstrb;
  logic        d_arready, d_rvalid, d_rlast, d_awready, d_wready, d_bvalid, protocol_err;
  logic [31:0] d_rdata;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] sb [$];

  always #5 clk = ~clk;

  dcache_axi_mem_slave #(.ADDR_W(14), .READ_LAT(READ_LAT), .WRITE_FIRST(1)) dut (
    .clk(clk), .rst(rst),
    .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
    .d_arready(d_arready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast),
    .d_rready(d_rready), .d_awvalid(d_awvalid), .d_awaddr(d_awaddr), .d_awlen(d_awlen),
    .d_awsize(d_awsize), .d_awready(d_awready), .d_wvalid(d_wvalid), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_wlast(d_wlast), .d_wready(d_wready), .d_bvalid(d_bvalid),
    .d_bready(d_bready), .protocol_err(protocol_err)
  );

  typedef struct {
    logic         do_wr;
    logic [31:0]  waddr;
    logic [7:0]   wlen;
    logic [3:0]   wstrb;
    logic [127:0] wdata;
    logic [31:0]  raddr;
    logic [7:0]   rlen;
    logic [127:0] rexp;
    logic [7:0]   rmask;
  } vec_t;

  localparam int NV = 7;
  vec_t vt [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [127:0] data,
                          input logic [3:0] strb, input int last_at, input logic exp_err);
    int t;
    logic ok;
    d_awvalid = 1'b1; d_awaddr = addr; d_awlen = len; d_awsize = 3'd2;
    ok = 1'b0; t = 0;
    while (!ok && t < 20) begin @(negedge clk); ok = d_awready; @(posedge clk); #1; t++; end
    d_awvalid = 1'b0;
    check("aw_handshake", ok, 1);
    for (int b = 0; b <= last_at; b++) begin
      d_wvalid = 1'b1; d_wdata = data[32*(b%4) +: 32]; d_wstrb = strb; d_wlast = (b == last_at);
      ok = 1'b0; t = 0;
      while (!ok && t < 20) begin @(negedge clk); ok = d_wready; @(posedge clk); #1; t++; end
      check("w_handshake", ok, 1);
    end
    d_wvalid = 1'b0; d_wlast = 1'b0;
    check("b_valid_after_last_w", d_bvalid, 1);
    check("protocol_err", protocol_err, exp_err);
    @(posedge clk); #1;
    check("b_valid_hold", d_bvalid, 1);
    d_bready = 1'b1;
    @(posedge clk); #1;
    d_bready = 1'b0;
    check("b_valid_cleared", d_bvalid, 0);
  endtask

  // Pushes expected beats, then consumes the burst with rready driven from mask.
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [127:0] exp,
                         input logic [7:0] mask, input int abort_at);
    int t, lat, got, cyc;
    logic ok, stalled;
    logic [32:0] held, e;
    for (int b = 0; b <= int'(len); b++) sb.push_back({(b == int'(len)), exp[32*b +: 32]});
    d_arvalid = 1'b1; d_araddr = addr; d_arlen = len; d_arsize = 3'd2;
    ok = 1'b0; t = 0;
    while (!ok && t < 20) begin @(negedge clk); ok = d_arready; @(posedge clk); #1; t++; end
    d_arvalid = 1'b0;
    check("ar_handshake", ok, 1);
    lat = 0;
    while (!d_rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("r_first_latency", lat, READ_LAT);
    got = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (got <= int'(len) && cyc < 64) begin
      if (abort_at != 0 && got == abort_at) break;
      d_rready = mask[cyc % 8];
      @(negedge clk);
      if (d_rvalid) begin
        if (stalled) check("r_stall_stable", {d_rlast, d_rdata}, held);
        if (d_rready) begin
          if (sb.size() == 0) check("r_extra_beat", 1, 0);
          else begin e = sb.pop_front(); check("r_beat", {d_rlast, d_rdata}, e); end
          got++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; held = {d_rlast, d_rdata};
        end
      end else begin
        check("r_valid_dropped", 0, 1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    d_rready = 1'b0;
    if (abort_at == 0) begin
      check("r_beat_count", got, int'(len) + 1);
      check("r_valid_after_last", d_rvalid, 0);
      check("scoreboard_empty", sb.size(), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 32'h1000, 8'd3, 4'hF, {32'hA3, 32'hA2, 32'hA1, 32'hA0},
              32'h1000, 8'd3, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'hFF};
    vt[1] = '{1'b1, 32'h2004, 8'd0, 4'hF, {96'h0, 32'h11223344},
              32'h2004, 8'd0, {96'h0, 32'h11223344}, 8'hFF};
    vt[2] = '{1'b1, 32'h2006, 8'd0, 4'b0100, {96'h0, 32'h00EE0000},
              32'h2004, 8'd0, {96'h0, 32'h11EE3344}, 8'hFF};
    vt[3] = '{1'b1, 32'hFFFC, 8'd1, 4'hF, {64'h0, 32'hCAFE0001, 32'hCAFE0000},
              32'hFFFC, 8'd1, {64'h0, 32'hCAFE0001, 32'hCAFE0000}, 8'hFF};
    vt[4] = '{1'b0, 32'h0, 8'd0, 4'h0, 128'h0,
              32'h0000, 8'd0, {96'h0, 32'hCAFE0001}, 8'hFF};
    vt[5] = '{1'b0, 32'h0, 8'd0, 4'h0, 128'h0,
              32'h0001_1003, 8'd3, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'b1001_1001};
    vt[6] = '{1'b1, 32'h1008, 8'd1, 4'b1000, {64'h0, 32'h88000000, 32'h77000000},
              32'h1000, 8'd3, {32'h880000A3, 32'h770000A2, 32'hA1, 32'hA0}, 8'hFF};

    rst = 1'b1;
    d_arvalid = 1'b0; d_araddr = '0; d_arlen = '0; d_arsize = '0; d_rready = 1'b0;
    d_awvalid = 1'b0; d_awaddr = '0; d_awlen = '0; d_awsize = '0;
    d_wvalid = 1'b0; d_wdata = '0; d_wstrb = '0; d_wlast = 1'b0; d_bready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {d_arready, d_awready, d_rvalid, d_rlast, d_wready, d_bvalid,
                            protocol_err, d_rdata}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle_readies", {d_arready, d_awready}, 2'b11);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].do_wr)
        do_write(vt[i].waddr, vt[i].wlen, vt[i].wdata, vt[i].wstrb, int'(vt[i].wlen), 1'b0);
      do_read(vt[i].raddr, vt[i].rlen, vt[i].rexp, vt[i].rmask, 0);
    end

    // Simultaneous AR and AW: write wins, read waits until B completes.
    d_arvalid = 1'b1; d_araddr = 32'h5000; d_arlen = 8'd0;
    d_awvalid = 1'b1; d_awaddr = 32'h5000; d_awlen = 8'd0;
    #1;
    check("arb_awready", d_awready, 1);
    check("arb_arready", d_arready, 0);
    @(posedge clk); #1;
    d_awvalid = 1'b0;
    check("arb_ar_blocked_wdata", d_arready, 0);
    d_wvalid = 1'b1; d_wdata = 32'h5A5A5A5A; d_wstrb = 4'hF; d_wlast = 1'b1;
    @(posedge clk); #1;
    d_wvalid = 1'b0; d_wlast = 1'b0;
    check("arb_bvalid", d_bvalid, 1);
    check("arb_ar_blocked_wresp", d_arready, 0);
    d_bready = 1'b1;
    @(posedge clk); #1;
    d_bready = 1'b0;
    check("arb_ar_ready_after_b", d_arready, 1);
    d_arvalid = 1'b0;
    do_read(32'h5000, 8'd0, {96'h0, 32'h5A5A5A5A}, 8'hFF, 0);

    // Early wlast: beats 2-3 keep their old contents.
    do_write(32'h4000, 8'd3, {32'h55553, 32'h55552, 32'h55551, 32'h55550}, 4'hF, 3, 1'b0);
    do_write(32'h4000, 8'd3, {32'h66663, 32'h66662, 32'h66661, 32'h66660}, 4'hF, 1, 1'b1);
    do_read(32'h4000, 8'd3, {32'h55553, 32'h55552, 32'h66661, 32'h66660}, 8'hFF, 0);

    // Asynchronous reset in the middle of a read burst.
    do_read(32'h1000, 8'd3, vt[6].rexp, 8'hFF, 2);
    rst = 1'b1;
    #1;
    check("midburst_reset_outputs", {d_arready, d_awready, d_rvalid, d_rlast, d_wready, d_bvalid,
                                     protocol_err, d_rdata}, 0);
    sb.delete();
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_readies", {d_arready, d_awready}, 2'b11);
    do_read(32'h1000, 8'd3, vt[6].rexp, 8'hFF, 0);

    // Missing wlast on the final beat: extra beat still accepted and written.
    do_write(32'h6000, 8'd0, {64'h0, 32'h6B, 32'h6A}, 4'hF, 1, 1'b1);
    do_read(32'h6000, 8'd1, {64'h0, 32'h6B, 32'h6A}, 8'hFF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
